// File: rtl/lfsr_22_checker_if.sv
// Stream and status bundle for the 22-bit LFSR pattern checker.
interface lfsr_22_checker_if #(
  parameter int ERR_W = 16
);
  logic             i_valid;
  logic [21:0]      i_data;
  logic             i_clear;
  logic             o_locked;
  logic             o_error;
  logic             o_wrap;
  logic [ERR_W-1:0] o_err_count;

  modport master (
    output i_valid, i_data, i_clear,
    input  o_locked, o_error, o_wrap, o_err_count
  );

  modport slave (
    input  i_valid, i_data, i_clear,
    output o_locked, o_error, o_wrap, o_err_count
  );
endinterface

// File: rtl/lfsr_22_checker.sv
// Self-synchronising checker for the XNOR 22-bit maximal-length LFSR stream.
// Optional error counter is built when LFSR_CHK_ERRCNT_EN is defined.
module lfsr_22_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  lfsr_22_checker_if.slave     bus
);
  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  localparam logic [21:0] ONES   = 22'h3FFFFF;
  localparam logic [3:0]  LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0]  LOSS_C = 4'(LOSS_COUNT);

  function automatic logic [21:0] nxt(input logic [21:0] s);
    return {s[20:0], ~(s[21] ^ s[20])};
  endfunction

  state_t      state, state_d;
  logic [21:0] expect_q, expect_d;
  logic [3:0]  match_cnt, match_d;
  logic [3:0]  miss_cnt, miss_d;
  logic        err_d, wrap_d;
  logic        locked_q, error_q, wrap_q;
  logic [3:0]  match_inc, miss_inc;
  logic        hit;

  assign hit       = (bus.i_data == expect_q);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;

  always_comb begin
    state_d  = state;
    expect_d = expect_q;
    match_d  = match_cnt;
    miss_d   = miss_cnt;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    if (bus.i_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.i_data != ONES) begin
            expect_d = nxt(bus.i_data);
            match_d  = 4'd0;
            state_d  = SYNC;
          end
        end
        SYNC: begin
          if (hit) begin
            match_d  = match_inc;
            expect_d = nxt(expect_q);
            if (match_inc == LOCK_C) begin
              state_d = LOCK;
              miss_d  = 4'd0;
            end
          end else if (bus.i_data == ONES) begin
            state_d = HUNT;
          end else begin
            expect_d = nxt(bus.i_data);
            match_d  = 4'd0;
          end
        end
        LOCK: begin
          // Flywheel: prediction keeps running regardless of received data.
          expect_d = nxt(expect_q);
          if (hit) begin
            miss_d = 4'd0;
            wrap_d = (bus.i_data == 22'h000000);
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == LOSS_C) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= HUNT;
      expect_q  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_d;
      expect_q  <= expect_d;
      match_cnt <= match_d;
      miss_cnt  <= miss_d;
      locked_q  <= (state_d == LOCK);
      error_q   <= err_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.o_locked = locked_q;
  assign bus.o_error  = error_q;
  assign bus.o_wrap   = wrap_q;

`ifdef LFSR_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;

  // Clear wins over the old value but an error in the same cycle still counts.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      err_cnt <= '0;
    else if (bus.i_clear)
      err_cnt <= err_d ? ERR_W'(1) : '0;
    else if (err_d && (err_cnt != '1))
      err_cnt <= err_cnt + ERR_W'(1);
  end

  assign bus.o_err_count = err_cnt;
`else
  logic unused_clear;
  assign unused_clear    = bus.i_clear;
  assign bus.o_err_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_22_checker.sv
// Vector table plus hand sequences for the LFSR checker, scored through a queue.
module tb_lfsr_22_checker;
  localparam int ERR_W = 16;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  lfsr_22_checker_if #(.ERR_W(ERR_W)) bus();

  lfsr_22_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(ERR_W)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  typedef struct {
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] cnt;
  } exp_t;

  typedef struct {
    bit vld;
    bit flip;
    bit ones;
    bit clr;
    bit locked;
    bit err;
    bit wrap;
    int cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic logic [21:0] gen_nxt(input logic [21:0] s);
    return {s[20:0], ~(s[21] ^ s[20])};
  endfunction

  // Inverse of the generator step, used to walk back from the all-zero word.
  function automatic logic [21:0] gen_prev(input logic [21:0] t);
    logic [21:0] s;
    s[20:0] = t[21:1];
    s[21]   = s[20] ^ ~t[0];
    return s;
  endfunction

  function automatic int ecnt(input int c);
`ifdef LFSR_CHK_ERRCNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic cmp1(input string nm, input logic act, input logic req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  task automatic check(input string nm);
    exp_t e;
    e = sb.pop_front();
    cmp1({nm, ".locked"}, bus.o_locked, e.locked);
    cmp1({nm, ".error"},  bus.o_error,  e.err);
    cmp1({nm, ".wrap"},   bus.o_wrap,   e.wrap);
    nvec++;
    if (bus.o_err_count !== e.cnt) begin
      nmis++;
      $display("FAIL %s.err_count: got %0d expected %0d", nm, bus.o_err_count, e.cnt);
    end
  endtask

  task automatic step(input logic v, input logic [21:0] d, input logic c,
                      input logic el, input logic ee, input logic ew, input int ec,
                      input string nm);
    exp_t e;
    @(negedge i_clk);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_clear = c;
    e.locked = el; e.err = ee; e.wrap = ew; e.cnt = ERR_W'(ecnt(ec));
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    check(nm);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_clear = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  function automatic vec_t mk(bit vld, bit flip, bit ones, bit clr,
                              bit locked, bit err, bit wrap, int cnt);
    vec_t r;
    r.vld = vld; r.flip = flip; r.ones = ones; r.clr = clr;
    r.locked = locked; r.err = err; r.wrap = wrap; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    logic [21:0] g, d;
    logic [21:0] w[8];
    int nv;

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_clear = 1'b0;
    do_reset();
    sb.push_back('{1'b0, 1'b0, 1'b0, '0});
    check("reset_state");

    // clean lock, single error, clear, loss/relock, clear+error
    repeat (4) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 3));
    repeat (4) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3));
    repeat (2) tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1));

    g = 22'h000000;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ones) d = 22'h3FFFFF;
      else if (tbl[i].vld) begin
        d = g ^ {21'd0, tbl[i].flip};
        g = gen_nxt(g);
      end else d = 22'($urandom());
      step(tbl[i].vld, d, tbl[i].clr, tbl[i].locked, tbl[i].err, tbl[i].wrap,
           tbl[i].cnt, $sformatf("tbl%0d", i));
    end

    // wrap through the all-zero word
    do_reset();
    w[7] = 22'h000000;
    for (int i = 6; i >= 0; i--) w[i] = gen_prev(w[i+1]);
    for (int i = 0; i < 8; i++)
      step(1'b1, w[i], 1'b0, i >= 4, 1'b0, i == 7, 0, $sformatf("wrap%0d", i));
    // a mispredicted zero word errors but does not wrap
    step(1'b1, 22'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1, "zero_miss");

    // asynchronous reset mid-lock
    @(negedge i_clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 22'h000000;
    #2 i_reset_n = 1'b0;
    #1;
    sb.push_back('{1'b0, 1'b0, 1'b0, '0});
    check("async_reset");
    do_reset();

    // lockup words ignored in HUNT, then a gappy clean stream
    repeat (3) step(1'b1, 22'h3FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, "lockup");
    g  = 22'($urandom()) & 22'h1FFFFF;
    nv = 0;
    for (int c = 0; c < 60 && nv < 7; c++) begin
      logic v;
      v = (c % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (v) begin
        d = g;
        g = gen_nxt(g);
        nv++;
      end else d = 22'($urandom());
      step(v, d, 1'b0, nv >= 5, 1'b0, 1'b0, 0, $sformatf("gap%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
